ndma_obi_sbr_mem: RTL
=====================

// Module: ndma_obi_sbr_mem
// PURPOSE
// - OBI subordinate (responder) backed by an internal word-addressed memory.
// - Serves as the source and target memory for NanoDMA read/write managers and their benches.
// - Grant latency is configurable (wait states). Response is fixed at one cycle after grant.
// - Out-of-range accesses return err. No rready: the manager always accepts responses.
// PARAMETERS
// - DEPTH     256  number of 32-bit words; power of 2, >= 2
// - GNT_WAIT  0    cycles req must be held before gnt; 0 = same-cycle grant
// - IDW       1    width of aid/rid
// PORTS
// - clk_i     in   1      clock, all logic on rising edge
// - rst_i     in   1      reset, synchronous, active-high
// - req_i     in   1      OBI request
// - gnt_o     out  1      OBI grant; combinational from req_i and internal state
// - addr_i    in   32     byte address; bits [1:0] ignored
// - we_i      in   1      1 = write, 0 = read
// - be_i      in   4      byte enables, writes only
// - wdata_i   in   32     write data
// - aid_i     in   IDW    transaction ID, echoed on rid_o
// - rvalid_o  out  1      response valid, exactly one cycle per granted transaction
// - rdata_o   out  32     read data; 0 for writes and for errors
// - err_o     out  1      response error (address out of range)
// - rid_o     out  IDW    ID of the transaction being responded to
// BEHAVIOUR
// - Reset (rst_i=1 at clock edge):
//   - rvalid_o=0, rdata_o=0, err_o=0, rid_o=0; FSM -> IDLE; wait counter=0.
//   - Memory contents are not cleared.
//   - gnt_o=0 while rst_i=1.
// - FSM states: IDLE and WAIT. Wait counter is $clog2(GNT_WAIT+1) bits, minimum 1.
//   - IDLE, req_i=1, GNT_WAIT=0: gnt_o=1 in the same cycle; stay in IDLE.
//   - IDLE, req_i=1, GNT_WAIT>0: gnt_o=0; counter<=1; -> WAIT.
//   - WAIT, req_i=1, counter<GNT_WAIT: counter++.
//   - WAIT, req_i=1, counter==GNT_WAIT: gnt_o=1, counter<=0, -> IDLE.
//   - WAIT, req_i=0: request withdrawn. Return to IDLE with counter=0; no transaction, no response.
//   - Result: gnt rises in the (GNT_WAIT+1)th consecutive cycle of req_i held high.
//   - The wait applies per transaction, including back-to-back requests.
// - Handshake:
//   - A transaction is accepted in the cycle req_i&gnt_o=1. Inputs are sampled only in that cycle.
//   - The manager holds addr/we/be/wdata/aid stable while req_i=1 and gnt_o=0. Changes are not checked.
// - Address decode:
//   - idx = addr_i[$clog2(DEPTH)+1:2].
//   - Out of range when addr_i[31:$clog2(DEPTH)+2] != 0.
// - Accepted write, in range: for each i with be_i[i]=1, mem[idx][8i+7:8i] <= wdata_i[8i+7:8i].
//   - Takes effect at the accepting edge. be_i=0000 is a legal no-op with a normal response.
// - Accepted read, in range: rdata_o <= mem[idx], registered at the accepting edge.
// - Response, next cycle after acceptance:
//   - rvalid_o=1, rid_o=accepted aid, err_o=out-of-range flag.
//   - rdata_o = read data, or 0 for writes and errors.
// - Out-of-range access: no memory update; err_o=1, rdata_o=0.
// - Pipelining: with GNT_WAIT=0, one transaction per cycle is sustained; rvalid_o stays high continuously.
// - A read in the cycle after a write to the same word returns the updated data.
// - When rvalid_o=0, rdata_o, err_o and rid_o are driven to 0.
// TESTING
// - GNT_WAIT=0: write 0xDEADBEEF @0x10 be=F, then read @0x10.
//   -> gnt same cycle as req; rvalid 1 cycle later; rdata=0xDEADBEEF, err=0.
// - Byte enables: write 0x11223344 @0x10 be=0101 over 0xDEADBEEF, then read @0x10 -> rdata=0xDE22BE44.
// - DEPTH=256: read @0x400 -> err=1, rdata=0. Write 0xFFFFFFFF @0x400, then read @0x0 -> original value unchanged.
// - GNT_WAIT=2: req held -> gnt only in 3rd cycle, rvalid in 4th.
//   Separately: req for 1 cycle, then 0 -> no gnt, no rvalid, FSM back in IDLE.
// - GNT_WAIT=0: 8 back-to-back reads of words 0..7 with aid alternating 0/1.
//   -> rvalid high for 8 consecutive cycles; rid and rdata match each request in order.
// - Reset mid-operation: assert rst_i in WAIT (GNT_WAIT=3) and in a cycle with a response pending.
//   -> next cycle rvalid=0, gnt=0, FSM IDLE; earlier written data still readable after reset.

Source files
------------

// File: rtl/ndma_obi_sbr_mem.sv
// OBI subordinate backed by a word-addressed internal memory.
// Source and target memory for the NanoDMA read/write managers and their benches.
//
// Ports:
//   clk_i     - clock, all logic on the rising edge
//   rst_i     - synchronous active-high reset (memory contents are kept)
//   req_i     - OBI request
//   gnt_o     - OBI grant, combinational from req_i and the wait-state FSM
//   addr_i    - byte address, bits [1:0] ignored
//   we_i      - 1 = write, 0 = read
//   be_i      - byte enables (writes only)
//   wdata_i   - write data
//   aid_i     - transaction ID, echoed on rid_o
//   rvalid_o  - response valid, one cycle after each grant
//   rdata_o   - read data; 0 for writes, errors and idle cycles
//   err_o     - address out of range
//   rid_o     - ID of the transaction being responded to
module ndma_obi_sbr_mem #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned GNT_WAIT = 0,
    parameter int unsigned IDW      = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic [31:0]     addr_i,
    input  logic            we_i,
    input  logic [3:0]      be_i,
    input  logic [31:0]     wdata_i,
    input  logic [IDW-1:0]  aid_i,
    output logic            rvalid_o,
    output logic [31:0]     rdata_o,
    output logic            err_o,
    output logic [IDW-1:0]  rid_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(GNT_WAIT);

    typedef enum logic {StIdle, StWait} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     mem [DEPTH];

    logic            rvalid_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [IDW-1:0]  rid_q;

    logic            accept;
    logic            in_range;
    logic [AW-1:0]   idx;
    logic            unused_addr;

    assign idx         = addr_i[AW+1:2];
    assign in_range    = (addr_i[31:AW+2] == '0);
    assign unused_addr = ^addr_i[1:0];

    // Grant is suppressed during reset; with wait states it only comes once the
    // counter has seen req held for GNT_WAIT cycles.
    always_comb begin
        gnt_o = 1'b0;
        if (!rst_i) begin
            if (GNT_WAIT == 0) begin
                gnt_o = req_i;
            end else begin
                gnt_o = req_i && (state_q == StWait) && (cnt_q == WAIT_MAX);
            end
        end
    end

    assign accept = req_i & gnt_o;

    // Wait-state FSM; unused (stays in StIdle) when GNT_WAIT == 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_i && (GNT_WAIT != 0)) begin
                        state_q <= StWait;
                        cnt_q   <= CW'(1);
                    end
                end
                StWait: begin
                    if (!req_i || (cnt_q == WAIT_MAX)) begin
                        // Withdrawn request or grant given: restart for the next one.
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Memory is deliberately not reset so data survives a reset pulse.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem[idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline: everything is zero unless a transaction was accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= accept;
            if (accept) begin
                rid_q   <= aid_i;
                err_q   <= !in_range;
                rdata_q <= (!we_i && in_range) ? mem[idx] : 32'h0;
            end else begin
                rid_q   <= '0;
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign rid_o    = rid_q;

endmodule
